apb_multi_slave_master: RTL and testbench

//  Parametrised APB4 master with N-slave decode, per-slave PREADY/PSLVERR/PRDATA muxing, upstream valid/ready request handshake,
//  one-cycle response pulse, back-to-back transfers, PREADY timeout and decode-error responses. Sits between the system-bus

---
 rtl/apb_multi_slave_master.sv | 200 ++++++++++++++++++++
 tb/tb_apb_multi_slave_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_slave_master.sv
// rtl/apb_multi_slave_master.sv - APB4 master with N-slave decode, timeout and decode-error responses
// Upstream valid/ready requests become single APB transfers; each accepted request yields one response pulse.
module apb_multi_slave_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int SLAVES_NUM     = 3,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             REQ_VALID,
  output logic                             REQ_READY,
  input  logic [ADDRESS_WIDTH-1:0]         REQ_ADDR,
  input  logic                             REQ_WRITE,
  input  logic [DATA_WIDTH-1:0]            REQ_WDATA,
  input  logic [STRB_WIDTH-1:0]            REQ_STRB,
  input  logic [2:0]                       REQ_PROT,
  output logic                             RSP_VALID,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic                             RSP_ERR,
  output logic                             RSP_TIMEOUT,
  output logic [SLAVES_NUM-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDRESS_WIDTH-1:0]         PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA,
  input  logic [SLAVES_NUM-1:0]            PREADY,
  input  logic [SLAVES_NUM-1:0]            PSLVERR
);

  localparam int SEL_BITS = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
  localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                  state_q, state_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

  logic [SEL_BITS-1:0]     req_idx;
  logic                    req_in_range;
  logic [SLAVES_NUM-1:0]   req_psel;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    timeout_hit;

  logic [SLAVES_NUM-1:0]   psel_d;
  logic                    penable_d;
  logic [ADDRESS_WIDTH-1:0] paddr_d;
  logic                    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_d;
  logic [2:0]              pprot_d;
  logic                    rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    rsp_err_d;
  logic                    rsp_timeout_d;

  assign req_idx      = REQ_ADDR[ADDRESS_WIDTH-1 -: SEL_BITS];
  assign req_in_range = (int'(req_idx) < SLAVES_NUM);

  // Only the captured slave's return signals matter; the others are ignored entirely.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    req_psel  = '0;
    for (int i = 0; i < SLAVES_NUM; i++) begin
      if (idx_q == SEL_BITS'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
      req_psel[i] = (req_idx == SEL_BITS'(i));
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && ((int'(to_cnt_q) + 1) >= TIMEOUT_CYCLES);

  // Ready in the completing ACCESS cycle lets the next transfer start without an IDLE bubble.
  assign REQ_READY = !PRESET &&
                     ((state_q == IDLE) || ((state_q == ACCESS) && sel_ready));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    to_cnt_d      = to_cnt_q;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    paddr_d       = PADDR;
    pwrite_d      = PWRITE;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    pprot_d       = PPROT;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = RSP_RDATA;
    rsp_err_d     = RSP_ERR;
    rsp_timeout_d = RSP_TIMEOUT;

    case (state_q)
      IDLE: ;
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = sel_err;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!PWRITE && !sel_err) ? sel_rdata : '0;
          psel_d        = '0;
          penable_d     = 1'b0;
          state_d       = IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          psel_d        = '0;
          penable_d     = 1'b0;
          to_cnt_d      = '0;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DERR: begin
        rsp_valid_d   = 1'b1;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        state_d       = IDLE;
      end
    endcase

    // A decode miss never touches the bus, so bus registers keep their last values.
    if (REQ_VALID && REQ_READY) begin
      idx_d     = req_idx;
      to_cnt_d  = '0;
      penable_d = 1'b0;
      if (req_in_range) begin
        psel_d   = req_psel;
        paddr_d  = REQ_ADDR;
        pwrite_d = REQ_WRITE;
        pprot_d  = REQ_PROT;
        if (REQ_WRITE) begin
          pwdata_d = REQ_WDATA;
          pstrb_d  = REQ_STRB;
        end else begin
          pstrb_d  = '0;
        end
        state_d = SETUP;
      end else begin
        psel_d  = '0;
        state_d = DERR;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERR     <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PADDR       <= paddr_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      PPROT       <= pprot_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_RDATA   <= rsp_rdata_d;
      RSP_ERR     <= rsp_err_d;
      RSP_TIMEOUT <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// tb/tb_apb_multi_slave_master.sv - randomized bench with a transaction-timeline reference model
// Each accepted request is turned into expected setup/access/response cycles and checked cycle by cycle.
module tb_apb_multi_slave_master;

  localparam int TO = 16;

  logic        PCLK;
  logic        PRESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [7:0]  REQ_ADDR;
  logic        REQ_WRITE;
  logic [31:0] REQ_WDATA;
  logic [3:0]  REQ_STRB;
  logic [2:0]  REQ_PROT;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [95:0] PRDATA;
  logic [2:0]  PREADY;
  logic [2:0]  PSLVERR;

  apb_multi_slave_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_WRITE(REQ_WRITE),
    .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB), .REQ_PROT(REQ_PROT),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          acc, s, e, rsp, idx;
    bit          valid, wr, err, to;
    logic [7:0]  addr;
    logic [31:0] wd, rd;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } txn_t;

  typedef struct {
    int          w;
    bit          se;
    logic [31:0] rd;
  } slv_t;

  txn_t exp_q[$];
  slv_t slv_q[$];
  bit   rsp_err_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_cnt  = 0;
  int last_rsp_cyc = 0;
  logic [31:0] last_rsp_rd;
  logic        last_rsp_err, last_rsp_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Slave responder: the slave taking part in a transfer answers after its programmed wait count.
  initial begin
    int          acc_cnt;
    slv_t        cur;
    logic [95:0] rdv;
    acc_cnt = 0;
    cur.w = 0; cur.se = 0; cur.rd = 0;
    PREADY = 0; PSLVERR = 0; PRDATA = 0;
    forever begin
      @(negedge PCLK);
      rdv     = {$urandom, $urandom, $urandom};
      PREADY  = 3'($urandom);
      PSLVERR = 3'($urandom);
      if (PENABLE && PSEL != 3'b000) begin
        for (int i = 0; i < 3; i++) begin
          if (PSEL[i]) begin
            if (acc_cnt == 0) begin
              n_checks++;
              if (slv_q.size() > 0) cur = slv_q.pop_front();
              else begin
                n_fail++;
                $display("FAIL unexpected_access: got access on PSEL %b expected none (cycle %0d)", PSEL, cyc);
              end
            end
            PREADY[i] = (acc_cnt == cur.w);
            if (PREADY[i]) begin
              PSLVERR[i]         = cur.se;
              rdv[i*32 +: 32]    = cur.rd;
            end
          end
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
      end
      PRDATA = rdv;
    end
  end

  // Compare process: derive expected bus and response values from the transaction timelines.
  initial begin
    logic [2:0]  exp_psel;
    logic        exp_pen, exp_rv, exp_ready, found;
    txn_t        bt, rt;
    logic [31:0] hold_rd, model_wd;
    logic        hold_err, hold_to;
    hold_rd = 0; hold_err = 0; hold_to = 0; model_wd = 0;
    forever begin
      @(negedge PCLK);
      #2;
      if (PRESET) begin
        chk("ready_in_reset", 64'(REQ_READY), 64'(0));
        exp_q.delete();
        hold_rd = 0; hold_err = 0; hold_to = 0; model_wd = 0;
        continue;
      end
      exp_psel = 0; exp_pen = 0; exp_rv = 0; exp_ready = 1; found = 0;
      foreach (exp_q[k]) begin
        if (exp_q[k].valid && cyc >= exp_q[k].s && cyc <= exp_q[k].e) begin
          bt       = exp_q[k];
          found    = 1;
          exp_psel = 3'b001 << bt.idx;
          exp_pen  = (cyc > bt.s);
        end
        if (cyc >= exp_q[k].acc + 1 && cyc <= exp_q[k].e &&
            !(cyc == exp_q[k].e && exp_q[k].valid && !exp_q[k].to))
          exp_ready = 0;
        if (cyc == exp_q[k].rsp) begin
          rt     = exp_q[k];
          exp_rv = 1;
        end
      end
      chk("psel", 64'(PSEL), 64'(exp_psel));
      chk("penable", 64'(PENABLE), 64'(exp_pen));
      chk("req_ready", 64'(REQ_READY), 64'(exp_ready));
      chk("rsp_valid", 64'(RSP_VALID), 64'(exp_rv));
      if (found) begin
        chk("paddr", 64'(PADDR), 64'(bt.addr));
        chk("pwrite", 64'(PWRITE), 64'(bt.wr));
        chk("pprot", 64'(PPROT), 64'(bt.prot));
        chk("pstrb", 64'(PSTRB), bt.wr ? 64'(bt.strb) : 64'(0));
        chk("pwdata", 64'(PWDATA), bt.wr ? 64'(bt.wd) : 64'(model_wd));
        if (cyc == bt.e && bt.wr) model_wd = bt.wd;
      end
      if (exp_rv) begin
        hold_rd = rt.rd; hold_err = rt.err; hold_to = rt.to;
      end
      chk("rsp_rdata", 64'(RSP_RDATA), 64'(hold_rd));
      chk("rsp_err", 64'(RSP_ERR), 64'(hold_err));
      chk("rsp_timeout", 64'(RSP_TIMEOUT), 64'(hold_to));
      if (RSP_VALID) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        last_rsp_rd  = RSP_RDATA;
        last_rsp_err = RSP_ERR;
        last_rsp_to  = RSP_TIMEOUT;
        rsp_err_log.push_back(RSP_ERR);
      end
      while (exp_q.size() > 0 && exp_q[0].rsp <= cyc) void'(exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] a, input bit wr, input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input int w, input bit se, input logic [31:0] rd,
                      output int acc);
    txn_t t;
    slv_t sv;
    bit   ok;
    REQ_ADDR = a; REQ_WRITE = wr; REQ_WDATA = wd; REQ_STRB = st; REQ_PROT = pr; REQ_VALID = 1'b1;
    ok  = 0;
    acc = -1;
    for (int b = 0; b < 60; b++) begin
      #1;
      if (REQ_READY) begin
        ok = 1;
        break;
      end
      @(negedge PCLK);
    end
    chk("accepted", 64'(ok), 64'(1));
    if (ok) begin
      acc    = cyc;
      t.acc  = acc;  t.addr = a; t.wr = wr; t.wd = wd; t.strb = st; t.prot = pr;
      t.idx  = int'(a[7:6]);
      t.valid = (t.idx < 3);
      if (t.valid) begin
        t.to  = (w >= TO);
        t.s   = acc + 1;
        t.e   = acc + 2 + (t.to ? TO - 1 : w);
        t.rsp = t.e + 1;
        t.err = t.to ? 1'b1 : se;
        t.rd  = (!wr && !t.to && !se) ? rd : 32'h0;
        sv.w = w; sv.se = se; sv.rd = rd;
        slv_q.push_back(sv);
      end else begin
        t.to = 0; t.s = acc + 1; t.e = acc + 1; t.rsp = acc + 2; t.err = 1; t.rd = 0;
      end
      exp_q.push_back(t);
    end
    @(negedge PCLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 40; i++) begin
      if (rsp_cnt >= target) break;
      @(negedge PCLK);
    end
    chk("rsp_arrived", 64'(rsp_cnt >= target), 64'(1));
  endtask

  initial begin
    int a1, a2, c0, w, gap, r;
    PRESET = 1'b1; REQ_VALID = 0; REQ_ADDR = 0; REQ_WRITE = 0; REQ_WDATA = 0; REQ_STRB = 0; REQ_PROT = 0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    #3;
    chk("reset_psel", 64'(PSEL), 64'(0));
    chk("reset_penable", 64'(PENABLE), 64'(0));
    chk("reset_rsp", 64'({RSP_VALID, RSP_ERR, RSP_TIMEOUT, RSP_RDATA}), 64'(0));
    chk("reset_bus", 64'({PADDR, PWRITE, PSTRB, PPROT}), 64'(0));
    chk("reset_pwdata", 64'(PWDATA), 64'(0));
    chk("ready_after_reset", 64'(REQ_READY), 64'(1));
    @(negedge PCLK);

    // Directed: single write, zero waits
    send(8'h10, 1, 32'hA5A5_0001, 4'hF, 3'd0, 0, 0, 32'h0, a1);
    wait_rsp(1);
    chk("t1_latency", 64'(last_rsp_cyc - a1), 64'(3));
    chk("t1_err", 64'(last_rsp_err), 64'(0));

    // Directed: read with 3 wait states
    send(8'h44, 0, 32'h1234_5678, 4'hF, 3'd2, 3, 0, 32'hDEAD_BEEF, a1);
    wait_rsp(2);
    chk("t2_latency", 64'(last_rsp_cyc - a1), 64'(6));
    chk("t2_rdata", 64'(last_rsp_rd), 64'(32'hDEAD_BEEF));

    // Directed: decode error
    send(8'hC4, 0, 32'h0, 4'h0, 3'd0, 0, 0, 32'h0, a1);
    wait_rsp(3);
    chk("t3_latency", 64'(last_rsp_cyc - a1), 64'(2));
    chk("t3_err_to", 64'({last_rsp_err, last_rsp_to}), 64'(2'b10));

    // Directed: timeout, and ready on the last permitted cycle
    send(8'h80, 0, 32'h0, 4'h0, 3'd0, 100, 0, 32'h5555_AAAA, a1);
    wait_rsp(4);
    chk("t4_latency", 64'(last_rsp_cyc - a1), 64'(18));
    chk("t4_err_to_rd", 64'({last_rsp_err, last_rsp_to, last_rsp_rd}), 64'({2'b11, 32'h0}));
    send(8'h80, 0, 32'h0, 4'h0, 3'd0, 15, 0, 32'h0BAD_F00D, a1);
    wait_rsp(5);
    chk("t4b_latency", 64'(last_rsp_cyc - a1), 64'(18));
    chk("t4b_rdata_to", 64'({last_rsp_to, last_rsp_rd}), 64'({1'b0, 32'h0BAD_F00D}));

    // Directed: back-to-back with slave error on the first
    send(8'h04, 1, 32'hCAFE_0004, 4'h3, 3'd1, 0, 1, 32'h0, a1);
    send(8'h48, 0, 32'h0, 4'h0, 3'd0, 0, 0, 32'h0000_0048, a2);
    chk("t5_b2b_gap", 64'(a2 - a1), 64'(2));
    wait_rsp(7);
    chk("t5_errs", 64'({rsp_err_log[rsp_err_log.size()-2], rsp_err_log[rsp_err_log.size()-1]}), 64'(2'b10));

    // Directed: reset during ACCESS drops the transfer without a response
    c0 = rsp_cnt;
    send(8'h40, 0, 32'h0, 4'h0, 3'd0, 10, 0, 32'h1111_2222, a1);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    #3;
    chk("t6_psel", 64'({PSEL, PENABLE}), 64'(0));
    chk("t6_ready", 64'(REQ_READY), 64'(1));
    repeat (20) @(negedge PCLK);
    chk("t6_no_rsp", 64'(rsp_cnt), 64'(c0));

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(9);
      if (r < 6)      w = $urandom_range(3);
      else if (r < 7) w = 15;
      else if (r < 8) w = 16 + $urandom_range(2);
      else            w = 4 + $urandom_range(4);
      send(8'($urandom), 1'($urandom), $urandom, 4'($urandom), 3'($urandom), w,
           ($urandom_range(4) == 0), $urandom, a1);
      gap = $urandom_range(2);
      repeat (gap) @(negedge PCLK);
    end
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge PCLK);
    end
    chk("drained", 64'(exp_q.size()), 64'(0));
    chk("slave_queue_empty", 64'(slv_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
